// File: rtl/pipelined_bypass_adder.sv
// Pipelined signed carry-bypass adder/subtractor with valid/ready handshake, latency STAGES.
// Define PBA_SATURATE_EN to clamp overflowing results to the signed limits in the final stage.
module pipelined_bypass_adder #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam int BPS  = NBLK / STAGES;
  localparam int MSB  = WIDTH - 1;

  // st_*[s] are the inputs seen by stage s: raw operands for s=0, registers after that
  logic [WIDTH-1:0] st_a [STAGES];
  logic [WIDTH-1:0] st_b [STAGES];
  logic [WIDTH-1:0] st_s [STAGES];
  logic             st_c [STAGES];
  logic             st_v [STAGES];

  logic             advance;
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  assign st_a[0] = a;
  assign st_b[0] = sub ? ~b : b;
  assign st_s[0] = '0;
  assign st_c[0] = sub | cin;
  assign st_v[0] = in_valid;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [WIDTH-1:0] s_d;
    logic             c_d;
    logic             rc;
    logic             p;
    int               idx;

    // Ripple inside each block; a fully propagating block forwards its carry-in directly
    always_comb begin
      s_d = st_s[s];
      c_d = st_c[s];
      rc  = 1'b0;
      p   = 1'b0;
      idx = 0;
      for (int k = 0; k < BPS; k++) begin
        rc = c_d;
        p  = 1'b1;
        for (int j = 0; j < BLOCK; j++) begin
          idx      = (s * BPS + k) * BLOCK + j;
          s_d[idx] = st_a[s][idx] ^ st_b[s][idx] ^ rc;
          rc       = (st_a[s][idx] & st_b[s][idx]) | (rc & (st_a[s][idx] ^ st_b[s][idx]));
          p        = p & (st_a[s][idx] ^ st_b[s][idx]);
        end
        c_d = p ? c_d : rc;
      end
    end

    if (s < STAGES - 1) begin : g_mid
      logic [WIDTH-1:0] a_q, b_q, s_q;
      logic             c_q, v_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
          c_q <= 1'b0;
          v_q <= 1'b0;
        end else if (advance) begin
          a_q <= st_a[s];
          b_q <= st_b[s];
          s_q <= s_d;
          c_q <= c_d;
          v_q <= st_v[s];
        end
      end

      assign st_a[s+1] = a_q;
      assign st_b[s+1] = b_q;
      assign st_s[s+1] = s_q;
      assign st_c[s+1] = c_q;
      assign st_v[s+1] = v_q;
    end else begin : g_last
      logic             ovf_d;
      logic [WIDTH-1:0] res_d;

      assign ovf_d = (st_a[s][MSB] == st_b[s][MSB]) && (s_d[MSB] != st_a[s][MSB]);
`ifdef PBA_SATURATE_EN
      assign res_d = !ovf_d ? s_d :
                     (st_a[s][MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}});
`else
      assign res_d = s_d;
`endif

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          sum_q       <= '0;
          cout_q      <= 1'b0;
          ovf_q       <= 1'b0;
        end else if (advance) begin
          out_valid_q <= st_v[s];
          sum_q       <= res_d;
          cout_q      <= c_d;
          ovf_q       <= ovf_d;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule
